uart_loader: RTL and testbench
==============================

# uart_loader

Serial program loader that sits upstream of the 6502 core's test memory. After reset it holds the CPU, receives an 8N1 UART byte stream carrying a load address, a length and a payload, and writes each payload byte into memory through a byte-wide write port. When the payload is complete it releases the CPU, which then starts fetching from its reset vector (0x0200).

## Interface
Parameters:
- CLKS_PER_BIT, 104: clock cycles per UART bit (12 MHz / 115200). Minimum 4.

Ports:
- clk  in  1  system clock, the same clock that drives the core.
- rst  in  1  reset; synchronous, active-high.
- rx  in  1  UART serial input; idle high; asynchronous to clk.
- mem_addr_l  out  8  write address, low byte.
- mem_addr_h  out  8  write address, high byte.
- mem_wdata  out  8  write data.
- mem_we  out  1  write strobe; one-cycle pulse per payload byte.
- cpu_hold  out  1  1 = core clock-gated/held; 0 = core may run.
- done  out  1  load complete; sticky until rst.
- err  out  1  framing or checksum error; sticky until rst.

## Operation
- rx passes through a 2-flop synchronizer. All logic uses the synchronized signal, rx_s.
- Receiver states: IDLE, START, BITS, STOP.
  - IDLE: waits for rx_s == 0.
  - START: after CLKS_PER_BIT/2 cycles (integer divide), samples rx_s. If rx_s is 1, treat as a glitch and return to IDLE with no error. If 0, go to BITS.
  - BITS: samples 8 bits LSB-first, one every CLKS_PER_BIT cycles, then goes to STOP.
  - STOP: samples after CLKS_PER_BIT. If rx_s is 1, pulse rx_valid for 1 cycle with rx_byte. If 0, raise a framing error.
- Loader states: ADDR_L, ADDR_H, LEN_L, LEN_H, DATA, CKSUM (macro only), DONE, ERROR.
  - Each rx_valid advances one header state and latches its byte into addr[15:0] or len[15:0].
  - On leaving LEN_H with len == 0: go directly to DONE (or to CKSUM when the macro is defined).
  - DATA: each rx_valid loads mem_wdata and pulses mem_we. addr increments and len decrements after the write. When len reaches 0, go to DONE (or to CKSUM).
  - Address wraps 0xFFFF → 0x0000 with no error.
  - DONE: done = 1, cpu_hold = 0. Further UART bytes are received and ignored; no writes.
  - ERROR: err = 1, cpu_hold stays 1, no writes. Only rst exits.
- A framing error in any loader state other than DONE sends the loader to ERROR.
- Reset values: mem_addr_l = 0x00, mem_addr_h = 0x00, mem_wdata = 0x00, mem_we = 0, cpu_hold = 1, done = 0, err = 0. The receiver and loader return to IDLE/ADDR_L.
- rst asserted mid-byte or mid-payload aborts the load immediately. Memory already written is not restored. The next byte after rst deassertion is treated as ADDR_L.

## Timing
- Synchronizer latency: 2 cycles from an rx edge to rx_s.
- rx_valid occurs CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after START entry, which is mid stop bit.
- mem_we is high the cycle after rx_valid. mem_addr_h/l and mem_wdata are stable during that cycle. The address increments on the following edge.
- done/cpu_hold change the cycle after the final mem_we, or the cycle after the checksum rx_valid when the macro is defined.
- Byte-to-byte spacing is at least 10·CLKS_PER_BIT, so a write never overlaps the next rx_valid.
- err rises the cycle after the failing sample or compare.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the payload (or directly after LEN_H when len == 0), one extra byte is expected in CKSUM.
  - It is compared against the 8-bit modulo-256 sum of all payload bytes.
  - Match → DONE. Mismatch → ERROR.
  - The checksum byte is never written to memory.
- LOADER_CHECKSUM_EN undefined: the CKSUM state and sum register are absent, and DATA completion goes directly to DONE.

## Test plan
- Nominal load: send 00 02 03 00 A9 05 EA. Required: writes 0x0200=A9, 0x0201=05, 0x0202=EA; three mem_we pulses; then done = 1, cpu_hold = 0, err = 0.
- Zero length: send 00 03 00 00. Required: no mem_we; done = 1 after LEN_H (macro off). With the macro on, additionally send 00 → done = 1.
- Wrap-around: send FF FF 02 00 11 22. Required: writes 0xFFFF=11, then 0x0000=22; done = 1.
- Framing error: send 00 02 with the stop bit of the second byte held low. Required: err = 1, cpu_hold stays 1; subsequent bytes produce no mem_we.
- Start glitch: pulse rx low for CLKS_PER_BIT/4 cycles, then send a valid 00 02 01 00 42. Required: no error; single write 0x0200=42; done = 1.
- With LOADER_CHECKSUM_EN, send 00 02 02 00 10 20 31. Required: err = 1, done = 0 (expected sum 0x30). Resending after rst with checksum 30 gives done = 1.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: serial program loader for the 6502 core's test memory.
//   After reset it holds the CPU, receives an 8N1 UART stream:
//   addr_l, addr_h, len_l, len_h, payload[len]. Each payload byte is written
//   through a byte-wide write port. When the payload is complete it releases
//   the CPU.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the payload. It must equal the
//   modulo-256 sum of the payload bytes, or the load ends in error.
//
// Parameter:
//   CLKS_PER_BIT  clock cycles per UART bit (minimum 4)
// Ports:
//   clk         system clock (same clock as the core)
//   rst         synchronous active-high reset
//   rx          UART serial input, idle high, asynchronous to clk
//   mem_addr_l  write address, low byte
//   mem_addr_h  write address, high byte
//   mem_wdata   write data
//   mem_we      one-cycle write strobe per payload byte
//   cpu_hold    1 = core held, 0 = core may run
//   done        load complete (sticky until rst)
//   err         framing/checksum error (sticky until rst)
module uart_loader #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] mem_addr_l,
  output logic [7:0] mem_addr_h,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       cpu_hold,
  output logic       done,
  output logic       err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  // ---------------- input synchronizer ----------------
  logic [1:0] r_sync;
  logic       w_rx_s;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rx};
  end

  assign w_rx_s = r_sync[1];

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  rx_state_t      r_rx_state, w_rx_next;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift;
  logic           w_half_tick, w_bit_tick;
  logic           w_rx_valid, w_frame_err;
  logic [7:0]     w_rx_byte;

  assign w_half_tick = (r_cnt == CW'(HALF - 1));
  assign w_bit_tick  = (r_cnt == CW'(CLKS_PER_BIT - 1));
  // By the time STOP is entered all eight data bits sit in the shifter.
  assign w_rx_byte   = r_shift;

  always_comb begin
    w_rx_next   = r_rx_state;
    w_rx_valid  = 1'b0;
    w_frame_err = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (!w_rx_s) w_rx_next = RX_START;
      // A start bit that is high again at mid-bit is a glitch: drop it silently.
      RX_START: if (w_half_tick) w_rx_next = w_rx_s ? RX_IDLE : RX_BITS;
      RX_BITS:  if (w_bit_tick && r_bit == 3'd7) w_rx_next = RX_STOP;
      RX_STOP: begin
        if (w_bit_tick) begin
          w_rx_next = RX_IDLE;
          if (w_rx_s) w_rx_valid  = 1'b1;
          else        w_frame_err = 1'b1;
        end
      end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      case (r_rx_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
        end
        RX_START: r_cnt <= w_half_tick ? '0 : r_cnt + 1'b1;
        RX_BITS: begin
          if (w_bit_tick) begin
            r_cnt <= '0;
            r_bit <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP:  r_cnt <= w_bit_tick ? '0 : r_cnt + 1'b1;
        default:  r_cnt <= '0;
      endcase
    end
  end

  // LSB-first shift of data bits; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (r_rx_state == RX_BITS && w_bit_tick) r_shift <= {w_rx_s, r_shift[7:1]};
  end

  // ---------------- loader ----------------
  typedef enum logic [2:0] {
    LD_ADDR_L, LD_ADDR_H, LD_LEN_L, LD_LEN_H, LD_DATA,
`ifdef LOADER_CHECKSUM_EN
    LD_CKSUM,
`endif
    LD_DONE, LD_ERROR
  } ld_state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t LD_PAYLOAD_END = LD_CKSUM;
  logic [7:0] r_sum;
`else
  localparam ld_state_t LD_PAYLOAD_END = LD_DONE;
`endif

  ld_state_t   r_ld_state, w_ld_next;
  logic [15:0] r_addr;
  logic [15:0] r_len;
  logic [7:0]  r_wdata;
  logic        r_we;

  always_comb begin
    w_ld_next = r_ld_state;
    case (r_ld_state)
      LD_ADDR_L: if (w_rx_valid) w_ld_next = LD_ADDR_H;
      LD_ADDR_H: if (w_rx_valid) w_ld_next = LD_LEN_L;
      LD_LEN_L:  if (w_rx_valid) w_ld_next = LD_LEN_H;
      LD_LEN_H:  if (w_rx_valid)
                   w_ld_next = ({w_rx_byte, r_len[7:0]} == 16'd0) ? LD_PAYLOAD_END : LD_DATA;
      // Completion is decided on the write cycle, when the last byte goes out.
      LD_DATA:   if (r_we && r_len == 16'd1) w_ld_next = LD_PAYLOAD_END;
`ifdef LOADER_CHECKSUM_EN
      LD_CKSUM:  if (w_rx_valid) w_ld_next = (w_rx_byte == r_sum) ? LD_DONE : LD_ERROR;
`endif
      LD_DONE:   w_ld_next = LD_DONE;
      LD_ERROR:  w_ld_next = LD_ERROR;
      default:   w_ld_next = LD_ERROR;
    endcase
    if (w_frame_err && r_ld_state != LD_DONE) w_ld_next = LD_ERROR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_state <= LD_ADDR_L;
      r_addr     <= '0;
      r_len      <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_ld_state <= w_ld_next;
      r_we       <= 1'b0;
      case (r_ld_state)
        LD_ADDR_L: if (w_rx_valid) r_addr[7:0]  <= w_rx_byte;
        LD_ADDR_H: if (w_rx_valid) r_addr[15:8] <= w_rx_byte;
        LD_LEN_L:  if (w_rx_valid) r_len[7:0]   <= w_rx_byte;
        LD_LEN_H:  if (w_rx_valid) r_len[15:8]  <= w_rx_byte;
        LD_DATA: begin
          if (w_rx_valid) begin
            r_wdata <= w_rx_byte;
            r_we    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= r_sum + w_rx_byte;
`endif
          end
          // Address/length advance after the strobe; 16-bit add wraps naturally.
          if (r_we) begin
            r_addr <= r_addr + 16'd1;
            r_len  <= r_len - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr_l = r_addr[7:0];
  assign mem_addr_h = r_addr[15:8];
  assign mem_wdata  = r_wdata;
  assign mem_we     = r_we;
  assign cpu_hold   = (r_ld_state != LD_DONE);
  assign done       = (r_ld_state == LD_DONE);
  assign err        = (r_ld_state == LD_ERROR);

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed self-checking bench for uart_loader.
//   Drives 8N1 frames on rx, records every mem_we write, and compares writes
//   and status outputs against hand-computed values. Follows
//   LOADER_CHECKSUM_EN when it is defined for the build.
module tb_uart_loader;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] mem_addr_l, mem_addr_h, mem_wdata;
  logic       mem_we, cpu_hold, done, err;

  int n_total = 0;
  int n_bad   = 0;

  uart_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .mem_addr_l(mem_addr_l), .mem_addr_h(mem_addr_h), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Write recorder: one entry per cycle with mem_we high.
  int          wcnt = 0;
  logic [15:0] waddr [64];
  logic [7:0]  wdat  [64];
  logic        done_at_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      waddr[wcnt % 64] <= {mem_addr_h, mem_addr_l};
      wdat[wcnt % 64]  <= mem_wdata;
      done_at_we       <= done;
      wcnt             <= wcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop;
    wait_cyc(CPB);
    rx = 1'b1;
    wait_cyc(2 * CPB);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  // Bounds the whole run in case the design never settles.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // ---- reset values (checked while rst is still asserted) ----
    rst = 1'b1;
    wait_cyc(4);
    check("rst_we",    mem_we,     1'b0);
    check("rst_hold",  cpu_hold,   1'b1);
    check("rst_done",  done,       1'b0);
    check("rst_err",   err,        1'b0);
    check("rst_addrl", mem_addr_l, 8'h00);
    check("rst_addrh", mem_addr_h, 8'h00);
    check("rst_wdata", mem_wdata,  8'h00);
    rst = 1'b0;
    wait_cyc(2);

    // ---- nominal load: 00 02 03 00 A9 05 EA ----
    base = wcnt;
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
    send_byte(8'hA9); send_byte(8'h05); send_byte(8'hEA);
`ifdef LOADER_CHECKSUM_EN
    check("nom_hold_pre_ck", cpu_hold, 1'b1);
    send_byte(8'h98);
`endif
    wait_cyc(4);
    check("nom_wcnt",  wcnt - base,  3);
    check("nom_a0",    waddr[base],   16'h0200);
    check("nom_d0",    wdat[base],    8'hA9);
    check("nom_a1",    waddr[base+1], 16'h0201);
    check("nom_d1",    wdat[base+1],  8'h05);
    check("nom_a2",    waddr[base+2], 16'h0202);
    check("nom_d2",    wdat[base+2],  8'hEA);
    check("nom_done_at_we", done_at_we, 1'b0);
    check("nom_done",  done,     1'b1);
    check("nom_hold",  cpu_hold, 1'b0);
    check("nom_err",   err,      1'b0);

    // bytes after DONE are ignored
    base = wcnt;
    send_byte(8'h55);
    wait_cyc(4);
    check("post_done_wcnt", wcnt - base, 0);
    check("post_done_done", done, 1'b1);

    // ---- zero length: 00 03 00 00 ----
    do_reset();
    base = wcnt;
    send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    check("zero_done_pre_ck", done, 1'b0);
    send_byte(8'h00);
`endif
    wait_cyc(4);
    check("zero_wcnt", wcnt - base, 0);
    check("zero_done", done, 1'b1);
    check("zero_err",  err,  1'b0);

    // ---- wrap-around: FF FF 02 00 11 22 ----
    do_reset();
    base = wcnt;
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h33);
`endif
    wait_cyc(4);
    check("wrap_wcnt", wcnt - base, 2);
    check("wrap_a0",   waddr[base],   16'hFFFF);
    check("wrap_d0",   wdat[base],    8'h11);
    check("wrap_a1",   waddr[base+1], 16'h0000);
    check("wrap_d1",   wdat[base+1],  8'h22);
    check("wrap_done", done, 1'b1);

    // ---- framing error on second header byte ----
    do_reset();
    base = wcnt;
    send_byte(8'h00);
    send_frame(8'h02, 1'b0);
    wait_cyc(12 * CPB);
    check("frm_err",  err,      1'b1);
    check("frm_hold", cpu_hold, 1'b1);
    check("frm_done", done,     1'b0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    wait_cyc(4);
    check("frm_wcnt",     wcnt - base, 0);
    check("frm_err_kept", err, 1'b1);

    // ---- start glitch, then 00 02 01 00 42 ----
    do_reset();
    base = wcnt;
    rx = 1'b0;
    wait_cyc(CPB / 4);
    rx = 1'b1;
    wait_cyc(3 * CPB);
    check("glt_err_early", err, 1'b0);
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h42);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h42);
`endif
    wait_cyc(4);
    check("glt_err",  err, 1'b0);
    check("glt_wcnt", wcnt - base, 1);
    check("glt_a0",   waddr[base], 16'h0200);
    check("glt_d0",   wdat[base],  8'h42);
    check("glt_done", done, 1'b1);

    // ---- reset mid-payload and mid-byte, then a fresh load ----
    do_reset();
    base = wcnt;
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h01);
    rx = 1'b0;
    wait_cyc(3 * CPB);
    rst = 1'b1;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(2);
    check("mid_addrl", mem_addr_l, 8'h00);
    check("mid_addrh", mem_addr_h, 8'h00);
    rst = 1'b0;
    wait_cyc(2 * CPB);
    check("mid_hold",  cpu_hold, 1'b1);
    check("mid_done",  done, 1'b0);
    check("mid_wcnt",  wcnt - base, 1);
    base = wcnt;
    send_byte(8'h40); send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h77);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h77);
`endif
    wait_cyc(4);
    check("mid2_wcnt", wcnt - base, 1);
    check("mid2_a0",   waddr[base], 16'h0240);
    check("mid2_d0",   wdat[base],  8'h77);
    check("mid2_done", done, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    // ---- checksum mismatch then match: 00 02 02 00 10 20 {31|30} ----
    do_reset();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
    wait_cyc(4);
    check("ck_bad_err",  err,  1'b1);
    check("ck_bad_done", done, 1'b0);
    do_reset();
    base = wcnt;
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    wait_cyc(4);
    check("ck_ok_wcnt", wcnt - base, 2);
    check("ck_ok_done", done, 1'b1);
    check("ck_ok_err",  err,  1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
